// File: rtl/global_ldst_r_buffer_pkg.sv
// System-side AXI typedefs shared by the global load-store R buffer and its
// surroundings, plus the R beat entry stored in the response FIFO.
package global_ldst_r_buffer_pkg;

  localparam int unsigned DefaultAxiDataWidth = 64;
  localparam int unsigned AxiAddrWidth        = 64;
  localparam int unsigned AxiIdWidth          = 5;
  localparam int unsigned AxiUserWidth        = 1;
  localparam int unsigned LenWidth            = 8;

  typedef logic [DefaultAxiDataWidth-1:0]   axi_data_t;
  typedef logic [DefaultAxiDataWidth/8-1:0] axi_strb_t;
  typedef logic [AxiAddrWidth-1:0]          axi_addr_t;
  typedef logic [AxiIdWidth-1:0]            axi_id_t;
  typedef logic [AxiUserWidth-1:0]          axi_user_t;
  typedef logic [LenWidth-1:0]              axi_len_t;

  typedef struct packed {
    axi_id_t   id;
    axi_addr_t addr;
    axi_len_t  len;
    logic [2:0] size;
    logic [1:0] burst;
    axi_user_t user;
  } axi_ax_chan_t;

  typedef struct packed {
    axi_data_t data;
    axi_strb_t strb;
    logic      last;
    axi_user_t user;
  } axi_w_chan_t;

  typedef struct packed {
    axi_id_t    id;
    logic [1:0] resp;
    axi_user_t  user;
  } axi_b_chan_t;

  typedef struct packed {
    axi_id_t    id;
    axi_data_t  data;
    logic [1:0] resp;
    logic       last;
    axi_user_t  user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } sys_axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } sys_axi_resp_t;

  // One buffered R beat; `last` is the crossbar's claim, kept only for checking.
  typedef struct packed {
    axi_data_t  data;
    axi_id_t    id;
    logic [1:0] resp;
    axi_user_t  user;
    logic       last;
  } r_entry_t;

endpackage

// File: rtl/global_ldst_r_buffer_fifo.sv
// Registered-output FIFO (no fall-through); full/empty come straight from the
// occupancy register so they never depend on same-cycle push/pop.
module global_ldst_r_buffer_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  dtype data_i,
  input  logic pop_i,
  output dtype data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth) + 1;
  typedef logic [PtrWidth-1:0] ptr_t;

  dtype                mem_q [Depth];
  ptr_t                wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] cnt_q;
  logic                push_ok, pop_ok;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/global_ldst_r_buffer.sv
// Read-response buffer between the global load-store unit and the system
// crossbar: caps in-flight AR bursts, registers R beats, regenerates r.last.
module global_ldst_r_buffer
  import global_ldst_r_buffer_pkg::*;
#(
  parameter int unsigned AxiDataWidth   = DefaultAxiDataWidth,
  parameter int unsigned Depth          = 4,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         axi_req_t      = sys_axi_req_t,
  parameter type         axi_resp_t     = sys_axi_resp_t
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  axi_req_t                          slv_req_i,
  output axi_resp_t                         slv_resp_o,
  output axi_req_t                          mst_req_o,
  input  axi_resp_t                         mst_resp_i,
  output logic [$clog2(MaxOutstanding):0]   outstanding_o,
  output logic                              last_err_o
);

  localparam int unsigned OutW = $clog2(MaxOutstanding) + 1;

  logic [OutW-1:0] outstanding_q;
  axi_len_t        beat_cnt_q, len_q, len_head;
  logic            last_err_q;
  r_entry_t        r_in, r_head;
  logic            r_full, r_empty, r_push, r_pop;
  logic            len_full, len_empty;
  logic            gate_open, ar_hs, last_gen, burst_done;

  // The len FIFO tracks outstanding one-for-one, so its full flag only
  // restates the counter limit.
  assign gate_open  = (outstanding_q < OutW'(MaxOutstanding)) & ~len_full;
  assign ar_hs      = slv_req_i.ar_valid & mst_resp_i.ar_ready & gate_open;
  assign r_push     = mst_resp_i.r_valid & ~r_full;
  assign r_pop      = ~r_empty & slv_req_i.r_ready;
  // A beat with no recorded burst is framed as a single-beat burst.
  assign len_head   = len_empty ? '0 : len_q;
  assign last_gen   = (beat_cnt_q == len_head);
  assign burst_done = r_pop & last_gen & ~len_empty;

  always_comb begin
    r_in      = '0;
    r_in.data = mst_resp_i.r.data[AxiDataWidth-1:0];
    r_in.id   = mst_resp_i.r.id;
    r_in.resp = mst_resp_i.r.resp;
    r_in.user = mst_resp_i.r.user;
    r_in.last = mst_resp_i.r.last;
  end

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid & gate_open;
    mst_req_o.r_ready  = ~r_full;

    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & gate_open;
    slv_resp_o.r_valid  = ~r_empty;
    slv_resp_o.r.data   = r_head.data;
    slv_resp_o.r.id     = r_head.id;
    slv_resp_o.r.resp   = r_head.resp;
    slv_resp_o.r.user   = r_head.user;
    slv_resp_o.r.last   = last_gen;
  end

  global_ldst_r_buffer_fifo #(
    .Depth (Depth),
    .dtype (r_entry_t)
  ) i_r_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .push_i  (r_push),
    .data_i  (r_in),
    .pop_i   (r_pop),
    .data_o  (r_head),
    .full_o  (r_full),
    .empty_o (r_empty)
  );

  global_ldst_r_buffer_fifo #(
    .Depth (MaxOutstanding),
    .dtype (axi_len_t)
  ) i_len_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .push_i  (ar_hs),
    .data_i  (slv_req_i.ar.len),
    .pop_i   (burst_done),
    .data_o  (len_q),
    .full_o  (len_full),
    .empty_o (len_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      beat_cnt_q    <= '0;
      last_err_q    <= 1'b0;
    end else begin
      unique case ({ar_hs, burst_done})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
      if (r_pop && !len_empty) beat_cnt_q <= last_gen ? '0 : beat_cnt_q + 1'b1;
      if (r_pop && (len_empty || (r_head.last != last_gen))) last_err_q <= 1'b1;
    end
  end

  assign outstanding_o = outstanding_q;
  assign last_err_o    = last_err_q;

endmodule

// File: tb/tb_global_ldst_r_buffer.sv
// Scenario bench for global_ldst_r_buffer: expected R beats ({last, data}) are
// queued when the crossbar side is driven and checked as they leave upstream.
module tb_global_ldst_r_buffer;
  import global_ldst_r_buffer_pkg::*;

  localparam int unsigned DW   = DefaultAxiDataWidth;
  localparam int unsigned W    = DW + 1;
  localparam int unsigned OutW = 3;

  logic          clk, rst;
  sys_axi_req_t  slv_req, mst_req;
  sys_axi_resp_t slv_resp, mst_resp;
  logic [OutW-1:0] outstanding;
  logic          last_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  global_ldst_r_buffer #(
    .AxiDataWidth   (DW),
    .Depth          (4),
    .MaxOutstanding (4),
    .axi_req_t      (sys_axi_req_t),
    .axi_resp_t     (sys_axi_resp_t)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .slv_req_i     (slv_req),
    .slv_resp_o    (slv_resp),
    .mst_req_o     (mst_req),
    .mst_resp_i    (mst_resp),
    .outstanding_o (outstanding),
    .last_err_o    (last_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required finish within 2 ms");
    $fatal(1);
  end

  // ---------------- scoreboard: upstream R handshakes ----------------
  always @(negedge clk) begin
    if (!rst && slv_resp.r_valid && slv_req.r_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL r_beat_unexpected: got last=%0b data=%h, required no beat",
                 slv_resp.r.last, slv_resp.r.data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({slv_resp.r.last, slv_resp.r.data} !== mon_exp) begin
          n_err++;
          $display("FAIL r_beat: got last=%0b data=%h, required last=%0b data=%h",
                   slv_resp.r.last, slv_resp.r.data, mon_exp[DW], mon_exp[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_ar(input logic [7:0] len);
    bit done = 1'b0;
    slv_req.ar.len   = len;
    slv_req.ar.id    = AxiIdWidth'($urandom_range(0, 31));
    slv_req.ar.addr  = {$urandom(), $urandom()};
    slv_req.ar_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (slv_resp.ar_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    slv_req.ar_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL ar_timeout: got ar_ready=0 for 50 cycles, required a handshake");
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] data, input logic last);
    bit done = 1'b0;
    mst_resp.r.data  = data;
    mst_resp.r.last  = last;
    mst_resp.r.id    = AxiIdWidth'($urandom_range(0, 31));
    mst_resp.r.resp  = 2'b00;
    mst_resp.r_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (mst_req.r_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    mst_resp.r_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL r_push_timeout: got r_ready=0 for 50 cycles, required a handshake");
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [AxiAddrWidth-1:0] addr;
    axi_id_t bid;
    addr = {$urandom(), $urandom()};
    bid  = AxiIdWidth'($urandom_range(0, 31));
    rst = 1'b1;
    slv_req = '0;
    mst_resp = '0;
    mst_resp.ar_ready = 1'b1;
    slv_req.ar_valid = 1'b1;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = addr;
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = bid;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (slv_resp.r_valid !== 1'b0) begin n_err++; $display("FAIL reset_r_valid: got %b, required 0", slv_resp.r_valid); end
    n_cmp++; if (mst_req.r_ready !== 1'b1) begin n_err++; $display("FAIL reset_r_ready: got %b, required 1", mst_req.r_ready); end
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL reset_outstanding: got %0d, required 0", outstanding); end
    n_cmp++; if (last_err !== 1'b0) begin n_err++; $display("FAIL reset_last_err: got %b, required 0", last_err); end
    n_cmp++; if (mst_req.ar_valid !== 1'b1) begin n_err++; $display("FAIL reset_ar_gate: got ar_valid=%b, required 1", mst_req.ar_valid); end
    n_cmp++; if (mst_req.aw.addr !== addr || mst_req.aw_valid !== 1'b1) begin n_err++; $display("FAIL aw_passthrough: got %h, required %h", mst_req.aw.addr, addr); end
    n_cmp++; if (slv_resp.b.id !== bid || slv_resp.b_valid !== 1'b1) begin n_err++; $display("FAIL b_passthrough: got %h, required %h", slv_resp.b.id, bid); end
    @(posedge clk); #1;
    slv_req.ar_valid = 1'b0;
    slv_req.aw_valid = 1'b0;
    mst_resp.b_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_burst();
    logic [DW-1:0] d [4];
    slv_req.r_ready = 1'b1;
    do_ar(8'd3);
    n_cmp++; if (outstanding !== 3'd1) begin n_err++; $display("FAIL single_outstanding_up: got %0d, required 1", outstanding); end
    n_cmp++; if (slv_resp.r_valid !== 1'b0) begin n_err++; $display("FAIL single_idle_valid: got %b, required 0", slv_resp.r_valid); end
    for (int i = 0; i < 4; i++) begin
      d[i] = rnd_data();
      exp_q.push_back({(i == 3), d[i]});
    end
    for (int i = 0; i < 4; i++) begin
      send_beat(d[i], (i == 3));
      n_cmp++;
      if (slv_resp.r_valid !== 1'b1 || slv_resp.r.data !== d[i]) begin
        n_err++;
        $display("FAIL single_latency beat %0d: got valid=%b data=%h, required valid=1 data=%h",
                 i, slv_resp.r_valid, slv_resp.r.data, d[i]);
      end
    end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL single_outstanding_down: got %0d, required 0", outstanding); end
    n_cmp++; if (last_err !== 1'b0) begin n_err++; $display("FAIL single_last_err: got %b, required 0", last_err); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL single_drain: got %0d beats left, required 0", exp_q.size()); end
  endtask

  task automatic test_outstanding_limit();
    logic [DW-1:0] d;
    slv_req.r_ready = 1'b1;
    for (int i = 0; i < 4; i++) do_ar(8'd0);
    n_cmp++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL limit_outstanding: got %0d, required 4", outstanding); end
    slv_req.ar.len   = 8'd0;
    slv_req.ar_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (slv_resp.ar_ready !== 1'b0) begin n_err++; $display("FAIL limit_ar_ready: got %b, required 0", slv_resp.ar_ready); end
    n_cmp++; if (mst_req.ar_valid !== 1'b0) begin n_err++; $display("FAIL limit_ar_valid: got %b, required 0", mst_req.ar_valid); end
    @(posedge clk); #1;
    d = rnd_data();
    exp_q.push_back({1'b1, d});
    send_beat(d, 1'b1);
    @(negedge clk);
    n_cmp++; if (slv_resp.ar_ready !== 1'b0) begin n_err++; $display("FAIL limit_hold_before_pop: got %b, required 0", slv_resp.ar_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (slv_resp.ar_ready !== 1'b1 || mst_req.ar_valid !== 1'b1) begin n_err++; $display("FAIL limit_release: got ready=%b valid=%b, required 1/1", slv_resp.ar_ready, mst_req.ar_valid); end
    @(posedge clk); #1;
    slv_req.ar_valid = 1'b0;
    n_cmp++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL limit_refill: got %0d, required 4", outstanding); end
    for (int i = 0; i < 4; i++) begin
      d = rnd_data();
      exp_q.push_back({1'b1, d});
      send_beat(d, 1'b1);
    end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL limit_drain: got %0d, required 0", outstanding); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d [8];
    int sent;
    sent = 0;
    slv_req.r_ready = 1'b0;
    do_ar(8'd7);
    for (int i = 0; i < 8; i++) begin
      d[i] = rnd_data();
      exp_q.push_back({(i == 7), d[i]});
    end
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_beat(d[i], (i == 7));
          sent++;
        end
      end
      begin
        repeat (10) @(negedge clk);
        n_cmp++; if (mst_req.r_ready !== 1'b0) begin n_err++; $display("FAIL bp_r_ready: got %b, required 0", mst_req.r_ready); end
        n_cmp++; if (sent != 4) begin n_err++; $display("FAIL bp_accepted: got %0d beats, required 4", sent); end
        @(posedge clk); #1;
        slv_req.r_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk); #1;
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain: got %0d beats left, required 0", exp_q.size()); end
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL bp_outstanding: got %0d, required 0", outstanding); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] d;
    slv_req.r_ready = 1'b0;
    do_ar(8'd0);
    do_ar(8'd0);
    n_cmp++; if (outstanding !== 3'd2) begin n_err++; $display("FAIL simul_setup: got %0d, required 2", outstanding); end
    d = rnd_data();
    exp_q.push_back({1'b1, d});
    send_beat(d, 1'b1);
    slv_req.ar.len   = 8'd0;
    slv_req.ar_valid = 1'b1;
    slv_req.r_ready  = 1'b1;
    @(negedge clk);
    n_cmp++; if (slv_resp.ar_ready !== 1'b1 || slv_resp.r_valid !== 1'b1) begin n_err++; $display("FAIL simul_both: got ar_ready=%b r_valid=%b, required 1/1", slv_resp.ar_ready, slv_resp.r_valid); end
    @(posedge clk); #1;
    slv_req.ar_valid = 1'b0;
    n_cmp++; if (outstanding !== 3'd2) begin n_err++; $display("FAIL simul_outstanding: got %0d, required 2", outstanding); end
    for (int i = 0; i < 2; i++) begin
      d = rnd_data();
      exp_q.push_back({1'b1, d});
      send_beat(d, 1'b1);
    end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL simul_drain: got %0d, required 0", outstanding); end
  endtask

  task automatic test_last_mismatch();
    logic [DW-1:0] d0, d1;
    slv_req.r_ready = 1'b1;
    d0 = rnd_data();
    d1 = rnd_data();
    do_ar(8'd1);
    exp_q.push_back({1'b0, d0});
    exp_q.push_back({1'b1, d1});
    send_beat(d0, 1'b1);
    @(negedge clk);
    n_cmp++; if (last_err !== 1'b0) begin n_err++; $display("FAIL mismatch_before_pop: got %b, required 0", last_err); end
    @(posedge clk); #1;
    send_beat(d1, 1'b0);
    n_cmp++; if (last_err !== 1'b1) begin n_err++; $display("FAIL mismatch_rise: got %b, required 1", last_err); end
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (last_err !== 1'b1) begin n_err++; $display("FAIL mismatch_sticky: got %b, required 1", last_err); end
    n_cmp++; if (outstanding !== 3'd0 || exp_q.size() != 0) begin n_err++; $display("FAIL mismatch_drain: got outstanding=%0d left=%0d, required 0/0", outstanding, exp_q.size()); end
  endtask

  task automatic test_reset_mid_burst();
    logic [DW-1:0] d;
    slv_req.r_ready = 1'b0;
    do_ar(8'd3);
    for (int i = 0; i < 3; i++) send_beat(rnd_data(), 1'b0);
    @(negedge clk);
    n_cmp++; if (slv_resp.r_valid !== 1'b1 || outstanding !== 3'd1) begin n_err++; $display("FAIL midrst_setup: got valid=%b outstanding=%0d, required 1/1", slv_resp.r_valid, outstanding); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (slv_resp.r_valid !== 1'b0) begin n_err++; $display("FAIL midrst_r_valid: got %b, required 0", slv_resp.r_valid); end
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL midrst_outstanding: got %0d, required 0", outstanding); end
    n_cmp++; if (last_err !== 1'b0) begin n_err++; $display("FAIL midrst_last_err: got %b, required 0", last_err); end
    n_cmp++; if (mst_req.r_ready !== 1'b1) begin n_err++; $display("FAIL midrst_r_ready: got %b, required 1", mst_req.r_ready); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    slv_req.r_ready = 1'b1;
    do_ar(8'd0);
    d = rnd_data();
    exp_q.push_back({1'b1, d});
    send_beat(d, 1'b1);
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (outstanding !== 3'd0 || last_err !== 1'b0) begin n_err++; $display("FAIL midrst_fresh: got outstanding=%0d err=%b, required 0/0", outstanding, last_err); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL midrst_drain: got %0d beats left, required 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_burst();
    test_outstanding_limit();
    test_backpressure();
    test_simultaneous();
    test_last_mismatch();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/global_ldst_r_buffer.md
# global_ldst_r_buffer

Elastic read-response buffer on the system side of the global load-store unit. It passes AW, W, B and AR between the global load-store unit and the system crossbar, and limits outstanding read bursts to a fixed number. It buffers R beats in a FIFO so the crossbar never sees combinational backpressure from the cluster fan-out. It also checks and regenerates `r.last` from the recorded AR length.

## Interface
- `AxiDataWidth`, default 0: system AXI data width in bits; must be set ≥ 64.
- `Depth`, default 4: R beat FIFO entries; power of two, ≥ 2.
- `MaxOutstanding`, default 4: maximum in-flight AR bursts; power of two, ≥ 1.
- `axi_req_t`, default logic: system AXI request struct.
- `axi_resp_t`, default logic: system AXI response struct.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `slv_req_i`  in  axi_req_t  request from the global load-store unit.
- `slv_resp_o`  out  axi_resp_t  response to the global load-store unit.
- `mst_req_o`  out  axi_req_t  request to the system crossbar.
- `mst_resp_i`  in  axi_resp_t  response from the system crossbar.
- `outstanding_o`  out  $clog2(MaxOutstanding)+1  number of accepted but unfinished read bursts.
- `last_err_o`  out  1  sticky flag: a crossbar `r.last` disagreed with the expected beat count.

## Operation
- **AW, W, B:** pure wires in both directions. No state.
- **AR gate:**
  - `mst_req_o.ar_valid = slv_req_i.ar_valid & (outstanding < MaxOutstanding)`.
  - `slv_resp_o.ar_ready = mst_resp_i.ar_ready & (outstanding < MaxOutstanding)`.
  - The AR payload passes through unchanged.
- **Len FIFO** (MaxOutstanding entries, 8 bits each):
  - Push `ar.len` on every AR handshake at the master side.
  - It is never full when a push is allowed, because the gate guarantees this.
- **R FIFO** (Depth entries):
  - Each entry holds data, id, resp, user and last.
  - `mst_req_o.r_ready = !r_full`.
  - Push on `mst_resp_i.r_valid & !r_full`.
  - `slv_resp_o.r_valid = !r_empty`; `slv_resp_o.r` is the FIFO head.
  - Pop on `slv_resp_o.r_valid & slv_req_i.r_ready`.
  - `slv_req_i.r_ready` is consumed directly, regardless of what drives it upstream.
- **Beat counter** (8 bits, output side):
  - It increments on each pop.
  - `slv_resp_o.r.last = (beat_cnt == len_head)`. The stored crossbar `last` is not used for this output.
  - On a pop with `beat_cnt == len_head`: pop the len FIFO, clear the counter, and decrement outstanding.
  - If a popped entry's stored `last` differs from the regenerated `last`, set `last_err_o`. It stays set until reset.
- **Outstanding counter:**
  - +1 on an AR handshake; −1 on a burst completion.
  - When both happen in the same cycle, the value is unchanged.
- **Data with no recorded burst:** an R beat arriving while the len FIFO is empty is still buffered. When it is popped, it is treated as `len_head = 0`, `last_err_o` is set, and the counter and outstanding are not changed.

## Timing
- **Reset values:**
  - `slv_resp_o.r_valid = 0`; `mst_req_o.r_ready = 1`; `mst_req_o.ar_valid` follows the gate with outstanding = 0.
  - `outstanding_o = 0`; `last_err_o = 0`; both FIFOs empty; beat counter 0.
- **Reset mid-burst:** asserting `rst_i` discards all buffered beats and pending lengths immediately (asynchronously).
- **Latency:** R beat accepted at cycle N is visible at `slv_resp_o` at cycle N+1. There is no fall-through.
- **Throughput:** 1 beat per cycle in steady state when Depth ≥ 2.
- **Full FIFO:** `mst_req_o.r_ready` depends only on the registered full flag. When full, a push is refused even if a pop happens in the same cycle; `r_ready` rises the cycle after the pop.
- **Empty FIFO:** `r_valid` stays low; `slv_req_i.r_ready` is ignored.
- **Combinational paths:** the only combinational paths are AR valid/ready, AW/W/B, and `ar_ready` through the gate.
- **Wrap-around:** FIFO pointers wrap modulo the depth. The beat counter never exceeds 255.

## Structure
- `fifo_v3` from common_cells is the natural sub-module, instantiated twice (R beats, lengths).
  - Drive its reset input with `~rst_i`.
  - Use `FALL_THROUGH = 0`.
- The R entry struct (data/id/resp/user/last) belongs in `ara_pkg`, alongside the existing AXI typedefs. It is derived from `AxiDataWidth`.
- No new constants; `MaxOutstanding` and `Depth` are supplied by the parent instantiation.

## Test plan
- **Single burst:**
  - Stimulus: AR len=3; crossbar returns 4 beats back-to-back with correct last; upstream `r_ready = 1`.
  - Response: 4 beats at output, each one cycle after entry; `r.last` only on beat 4; outstanding 0→1→0; `last_err_o = 0`.
- **Outstanding limit:**
  - Stimulus: MaxOutstanding=4; issue 5 ARs with no R traffic.
  - Response: 4 handshakes; the 5th is held, `ar_ready = 0` and `ar_valid = 0` to the crossbar; `outstanding_o = 4`. The 5th is released the cycle after the first burst completes.
- **Backpressure:**
  - Stimulus: Depth=4; upstream `r_ready = 0`; crossbar streams 8 beats.
  - Response: `mst_req_o.r_ready` drops after 4 beats. Once upstream `r_ready = 1`, all 8 beats are delivered in order with no loss or duplication.
- **Last mismatch:**
  - Stimulus: AR len=1; crossbar sets last on beat 1.
  - Response: output `last` is asserted on beat 2 only; `last_err_o` rises on the beat 1 pop and stays high.
- **Simultaneous AR and completion:**
  - Stimulus: outstanding=2; an AR handshake and the final-beat pop in the same cycle.
  - Response: `outstanding_o` stays 2.
- **Reset mid-burst:**
  - Stimulus: `rst_i` pulse with 3 beats buffered.
  - Response: `r_valid = 0`, `outstanding_o = 0` and `last_err_o = 0` immediately; a fresh len=0 burst afterwards completes normally.
